// File: rtl/regfile_wren_guard_if.sv
// rtl/regfile_wren_guard_if.sv - strobe/address/enable bus and error outputs of the write-enable guard
//
// Purpose : groups the signals the guard observes with the error flags it reports.
// Signals :
//   oh_i         decoded write strobes (OneHotWidth bits)
//   addr_i       encoded write address (AddrWidth bits)
//   en_i         global write enable
//   err_o        registered error flag
//   err_cause_o  registered causes: bit0 multi-hot, bit1 address, bit2 enable
//   err_sticky_o latched error flag
// Modports: master drives the observed bus and reads errors; slave is the guard.
interface regfile_wren_guard_if #(
   parameter int AddrWidth   = 4,
   parameter int OneHotWidth = 2**AddrWidth
);
   logic [OneHotWidth-1:0] oh_i;
   logic [AddrWidth-1:0]   addr_i;
   logic                   en_i;
   logic                   err_o;
   logic [2:0]             err_cause_o;
   logic                   err_sticky_o;

   modport master (
      output oh_i, addr_i, en_i,
      input  err_o, err_cause_o, err_sticky_o
   );

   modport slave (
      input  oh_i, addr_i, en_i,
      output err_o, err_cause_o, err_sticky_o
   );
endinterface

// File: rtl/regfile_wren_guard.sv
// rtl/regfile_wren_guard.sv - fault checker for decoded register-file write-enable strobes
//
// Purpose : flags spurious, multiple or misrouted write strobes by comparing the
//           one-hot strobe vector with the encoded address and global enable.
// Ports   :
//   clk_i  sole clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    regfile_wren_guard_if.slave (oh_i, addr_i, en_i in; err_o,
//          err_cause_o, err_sticky_o out)
// Macro   : REGFILE_WREN_GUARD_STICKY_EN - when defined err_sticky_o latches any
//           error until reset; when undefined it is tied low and no flop exists.
module regfile_wren_guard #(
   parameter int AddrWidth   = 4,
   parameter int OneHotWidth = 2**AddrWidth,
   parameter bit AddrCheck   = 1'b1,
   parameter bit EnableCheck = 1'b1
) (
   input logic                clk_i,
   input logic                rst_i,
   regfile_wren_guard_if.slave bus
);

   if (OneHotWidth < 1) begin : g_bad_width
      $error("regfile_wren_guard: OneHotWidth must be at least 1");
   end
   if (AddrCheck && (OneHotWidth > 2**AddrWidth)) begin : g_bad_addr
      $error("regfile_wren_guard: OneHotWidth exceeds the address range");
   end

   localparam logic [31:0] OhWidthU = 32'(OneHotWidth);

   // Separate buffer so synthesis keeps the checker's copy of the strobes
   // apart from the decoder it is supposed to be watching.
   (* keep = "true", dont_touch = "true" *) logic [OneHotWidth-1:0] oh_buf;
   assign oh_buf = bus.oh_i;

   logic [31:0] addr_ext;
   assign addr_ext = 32'(bus.addr_i);

   logic [31:0] pop;
   logic [31:0] idx;
   logic        any;
   logic        multi;
   logic [2:0]  cause_d;
   logic [2:0]  cause_q;

   always_comb begin
      pop = 32'd0;
      idx = 32'd0;
      for (int k = 0; k < OneHotWidth; k++) begin
         if (oh_buf[k]) begin
            pop = pop + 32'd1;
            idx = k[31:0];
         end
      end
   end

   assign any   = |oh_buf;
   assign multi = (pop > 32'd1);

   always_comb begin
      cause_d    = 3'b000;
      cause_d[0] = multi;
      // Address check stands down when several strobes fire; the multi-hot
      // cause already reports that situation.
      if (AddrCheck && !multi) begin
         cause_d[1] = ((pop == 32'd1) && (idx != addr_ext)) ||
                      (bus.en_i && (addr_ext >= OhWidthU));
      end
      if (EnableCheck) begin
         cause_d[2] = (any != bus.en_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cause_q <= 3'b000;
      end else begin
         cause_q <= cause_d;
      end
   end

   assign bus.err_cause_o = cause_q;
   assign bus.err_o       = |cause_q;

`ifdef REGFILE_WREN_GUARD_STICKY_EN
   logic sticky_d;
   logic sticky_q;

   assign sticky_d = sticky_q | (|cause_d);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign bus.err_sticky_o = sticky_q;
`else
   assign bus.err_sticky_o = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wren_guard.sv
// tb/tb_regfile_wren_guard.sv - self-checking bench for regfile_wren_guard
module tb_regfile_wren_guard;

   localparam int AW = 4;
   localparam int OW = 16;

`ifdef REGFILE_WREN_GUARD_STICKY_EN
   localparam bit StickyOn = 1'b1;
`else
   localparam bit StickyOn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_wren_guard_if #(.AddrWidth(AW), .OneHotWidth(OW)) bus_a ();
   regfile_wren_guard_if #(.AddrWidth(AW), .OneHotWidth(OW)) bus_b ();

   regfile_wren_guard #(.AddrWidth(AW), .OneHotWidth(OW), .AddrCheck(1'b1), .EnableCheck(1'b1))
      dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a.slave));
   regfile_wren_guard #(.AddrWidth(AW), .OneHotWidth(OW), .AddrCheck(1'b0), .EnableCheck(1'b1))
      dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b.slave));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference rules: multi-hot if more than one strobe; misroute if the single
   // strobe is not the one the address selects (or an enable targets an address
   // with no strobe line); enable fault if "some strobe" disagrees with en.
   function automatic logic [2:0] model(input logic [OW-1:0] oh, input logic [AW-1:0] addr,
                                        input logic en, input bit acheck);
      logic [2:0]    c;
      logic [OW-1:0] want;
      int            n;
      n    = $countones(oh);
      want = '0;
      if (int'(addr) < OW) want[addr] = 1'b1;
      c[0] = (n > 1);
      c[1] = acheck && (n <= 1) &&
             (((n == 1) && (oh != want)) || (en && (int'(addr) >= OW)));
      c[2] = ((oh != '0) != en);
      return c;
   endfunction

   logic [2:0] exp_a, exp_b;
   logic       exp_stk_a, exp_stk_b;

   always @(posedge clk) begin
      if (rst) begin
         exp_a     = 3'b000;
         exp_b     = 3'b000;
         exp_stk_a = 1'b0;
         exp_stk_b = 1'b0;
      end else begin
         exp_a = model(bus_a.oh_i, bus_a.addr_i, bus_a.en_i, 1'b1);
         exp_b = model(bus_b.oh_i, bus_b.addr_i, bus_b.en_i, 1'b0);
         exp_stk_a = StickyOn && (exp_stk_a || (exp_a != 3'b000));
         exp_stk_b = StickyOn && (exp_stk_b || (exp_b != 3'b000));
      end
      #1;
      check("model_cause_a",  32'(bus_a.err_cause_o),  32'(exp_a));
      check("model_err_a",    32'(bus_a.err_o),        32'(exp_a != 3'b000));
      check("model_sticky_a", 32'(bus_a.err_sticky_o), 32'(exp_stk_a));
      check("model_cause_b",  32'(bus_b.err_cause_o),  32'(exp_b));
      check("model_err_b",    32'(bus_b.err_o),        32'(exp_b != 3'b000));
      check("model_sticky_b", 32'(bus_b.err_sticky_o), 32'(exp_stk_b));
   end

   typedef struct {
      logic          rst;
      logic [OW-1:0] oh;
      logic [AW-1:0] addr;
      logic          en;
      logic [2:0]    cause_a;
      logic [2:0]    cause_b;
      logic          stk;
   } vec_t;

   vec_t vecs[$];

   initial begin
      bus_a.oh_i = 16'h0003; bus_a.addr_i = '0; bus_a.en_i = 1'b0;
      bus_b.oh_i = 16'h0003; bus_b.addr_i = '0; bus_b.en_i = 1'b0;

      //          rst   oh        addr  en    cause_a  cause_b  sticky(if enabled)
      vecs.push_back('{1'b1, 16'h0003, 4'd0,  1'b0, 3'b000, 3'b000, 1'b0});
      vecs.push_back('{1'b1, 16'h0003, 4'd0,  1'b0, 3'b000, 3'b000, 1'b0});
      vecs.push_back('{1'b0, 16'h0000, 4'd9,  1'b0, 3'b000, 3'b000, 1'b0});
      vecs.push_back('{1'b0, 16'h0020, 4'd5,  1'b1, 3'b000, 3'b000, 1'b0});
      vecs.push_back('{1'b0, 16'h0006, 4'd2,  1'b1, 3'b001, 3'b001, 1'b1});
      vecs.push_back('{1'b0, 16'h0010, 4'd3,  1'b1, 3'b010, 3'b000, 1'b1});
      vecs.push_back('{1'b0, 16'h0100, 4'd8,  1'b0, 3'b100, 3'b100, 1'b1});
      vecs.push_back('{1'b0, 16'h0000, 4'd4,  1'b0, 3'b000, 3'b000, 1'b1});
      vecs.push_back('{1'b0, 16'h0000, 4'd7,  1'b1, 3'b100, 3'b100, 1'b1});
      vecs.push_back('{1'b0, 16'h0080, 4'd7,  1'b1, 3'b000, 3'b000, 1'b1});
      vecs.push_back('{1'b0, 16'h0011, 4'd0,  1'b0, 3'b101, 3'b101, 1'b1});
      vecs.push_back('{1'b0, 16'h0001, 4'd1,  1'b1, 3'b010, 3'b000, 1'b1});
      vecs.push_back('{1'b0, 16'h8000, 4'd15, 1'b1, 3'b000, 3'b000, 1'b1});
      vecs.push_back('{1'b0, 16'h0020, 4'd5,  1'b1, 3'b000, 3'b000, 1'b1});
      vecs.push_back('{1'b1, 16'h0006, 4'd2,  1'b1, 3'b000, 3'b000, 1'b0});
      vecs.push_back('{1'b0, 16'h0000, 4'd0,  1'b0, 3'b000, 3'b000, 1'b0});
      vecs.push_back('{1'b0, 16'h0002, 4'd1,  1'b1, 3'b000, 3'b000, 1'b0});

      foreach (vecs[i]) begin
         @(negedge clk);
         rst          = vecs[i].rst;
         bus_a.oh_i   = vecs[i].oh;   bus_b.oh_i   = vecs[i].oh;
         bus_a.addr_i = vecs[i].addr; bus_b.addr_i = vecs[i].addr;
         bus_a.en_i   = vecs[i].en;   bus_b.en_i   = vecs[i].en;
         @(posedge clk);
         #2;
         check($sformatf("vec%0d_cause_a", i), 32'(bus_a.err_cause_o), 32'(vecs[i].cause_a));
         check($sformatf("vec%0d_err_a", i),   32'(bus_a.err_o),       32'(vecs[i].cause_a != 3'b000));
         check($sformatf("vec%0d_cause_b", i), 32'(bus_b.err_cause_o), 32'(vecs[i].cause_b));
         check($sformatf("vec%0d_sticky", i),  32'(bus_a.err_sticky_o), 32'(StickyOn && vecs[i].stk));
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
